hack_screen_scanout: RTL



---
 rtl/hack_screen_scanout.sv | 93 +++++++++
 1 files changed

// File: rtl/hack_screen_scanout.sv
// hack_screen_scanout: scans the Hack 512x256 1bpp screen RAM out as centred 640x480@60 VGA.
// Optional SCANOUT_INVERT_EN adds an `invert` input latched once per frame to swap FG/BG.
module hack_screen_scanout #(
    parameter int          CLK_DIV   = 2,
    parameter int          X_OFS     = 64,
    parameter int          Y_OFS     = 112,
    parameter logic [11:0] FG_COLOR  = 12'h000,
    parameter logic [11:0] BG_COLOR  = 12'hFFF,
    parameter logic [11:0] BRD_COLOR = 12'h008
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef SCANOUT_INVERT_EN
    input  logic        invert,
`endif
    output logic        rd_en,
    output logic [12:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);
    logic [1:0]  div;
    logic [9:0]  h, v, hx, wx, wy;
    logic [15:0] next_word, shifter;
    logic [11:0] rgb;
    logic        pix_ce, rd_pend, in_win, fetch, load, bit_val, inv;

    always_comb begin
        pix_ce  = div == 2'(CLK_DIV - 1);
        hx      = h - 10'(X_OFS - 8);
        wx      = h - 10'(X_OFS);
        wy      = v - 10'(Y_OFS);
        in_win  = wx < 10'd512 && wy < 10'd256;
        fetch   = wy < 10'd256 && hx < 10'd512 && hx[3:0] == 4'd0;
        load    = in_win && wx[3:0] == 4'd0;
        // the first pixel of each word comes straight from next_word, the rest from the shifter
        bit_val = load ? next_word[0] : shifter[0];
    end

`ifdef SCANOUT_INVERT_EN
    logic inv_q;
    always_ff @(posedge clk)
        inv_q <= !reset_n ? 1'b0 : (pix_ce && h == 10'd0 && v == 10'd0) ? invert : inv_q;
    assign inv = inv_q;
`else
    assign inv = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            rd_pend     <= 1'b0;
            next_word   <= '0;
            shifter     <= '0;
            rgb         <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div <= pix_ce ? 2'd0 : div + 2'd1;
            if (pix_ce) begin
                h       <= h == 10'd799 ? 10'd0 : h + 10'd1;
                v       <= h != 10'd799 ? v : v == 10'd524 ? 10'd0 : v + 10'd1;
                shifter <= load ? next_word >> 1 : shifter >> 1;
            end
            rd_en <= pix_ce && fetch;
            if (pix_ce && fetch)
                rd_addr <= {wy[7:0], hx[8:4]};
            // RAM returns data the clk after it sees rd_en, so capture one clk later still
            rd_pend <= rd_en;
            if (rd_pend)
                next_word <= rd_data;
            rgb <= (h >= 10'd640 || v >= 10'd480) ? 12'h000 :
                   !in_win ? BRD_COLOR :
                   (bit_val ^ inv) ? FG_COLOR : BG_COLOR;
            vga_hs      <= !(h >= 10'd656 && h <= 10'd751);
            vga_vs      <= !(v >= 10'd490 && v <= 10'd491);
            frame_start <= h == 10'd0 && v == 10'd0 && div == 2'd0;
        end
    end

    assign vga_r = rgb[11:8];
    assign vga_g = rgb[7:4];
    assign vga_b = rgb[3:0];
endmodule
